// File: rtl/fib_pkg.sv
// +----------------------------------------------------------------------+
// | fib_pkg                                                              |
// | Shared state encoding and default widths for the Fibonacci scheduler.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fib_pkg;

  localparam int c_DATA_W = 16;
  localparam int c_LEN_W  = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fib_core.sv
// +----------------------------------------------------------------------+
// | fib_core                                                             |
// | Fibonacci term generator: clear restarts at F0, advance steps once.  |
// | Optional carry output under FIB_SCHED_OVF_EN.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fib_core
  import fib_pkg::*;
#(
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
`ifdef FIB_SCHED_OVF_EN
  output logic              carry,
`endif
  output logic [DATA_W-1:0] term
);

  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_nxt;

`ifdef FIB_SCHED_OVF_EN
  logic [DATA_W:0] w_sum;
  logic            r_cur_carry;
  logic            r_nxt_carry;

  assign w_sum = {1'b0, r_cur} + {1'b0, r_nxt};

  // Carry travels with the term it produced, so it is reported when that term is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_carry <= 1'b0;
      r_nxt_carry <= 1'b0;
    end else if (clear) begin
      r_cur_carry <= 1'b0;
      r_nxt_carry <= 1'b0;
    end else if (advance) begin
      r_cur_carry <= r_nxt_carry;
      r_nxt_carry <= w_sum[DATA_W];
    end
  end

  assign carry = r_cur_carry;
`else
  logic [DATA_W-1:0] w_sum;

  assign w_sum = r_cur + r_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur <= '0;
      r_nxt <= {{(DATA_W-1){1'b0}}, 1'b1};
    end else if (clear) begin
      r_cur <= '0;
      r_nxt <= {{(DATA_W-1){1'b0}}, 1'b1};
    end else if (advance) begin
      r_cur <= r_nxt;
      r_nxt <= w_sum[DATA_W-1:0];
    end
  end

  assign term = r_cur;

endmodule

`default_nettype wire

// File: rtl/fib_sched.sv
// +----------------------------------------------------------------------+
// | fib_sched                                                            |
// | Two-requester round-robin scheduler emitting Fibonacci bursts over a |
// | valid/ready stream. Macro FIB_SCHED_OVF_EN enables sticky overflow.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fib_sched
  import fib_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int LEN_W  = c_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  localparam logic [LEN_W-1:0] c_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_prio;
  logic              r_id;
  logic              r_gnt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              w_grant;
  logic              w_win;
  logic              w_xfer;
  logic              w_last;
  logic              w_done;
  logic [DATA_W-1:0] w_term;

  // On a tie the pointer decides; otherwise the lone requester wins.
  assign w_win   = (req0 && req1) ? r_prio : req1;
  assign w_grant = (r_state == IDLE) && (req0 || req1);

  assign out_valid = (r_state == RUN) && (r_len != '0);
  assign w_last    = (r_cnt == (r_len - c_ONE));
  assign w_xfer    = out_valid && out_ready;
  assign w_done    = (r_state == RUN) && ((r_len == '0) || (w_xfer && w_last));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = RUN;
      RUN:     if (w_done)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_id    <= 1'b0;
      r_gnt   <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_grant;
      if (w_grant) begin
        r_len  <= w_win ? len1 : len0;
        r_id   <= w_win;
        r_prio <= ~w_win;
        r_cnt  <= '0;
      end else if (w_xfer && !w_last) begin
        r_cnt  <= r_cnt + c_ONE;
      end
    end
  end

`ifdef FIB_SCHED_OVF_EN
  logic w_carry;
  logic r_ovf;

  fib_core #(.DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == IDLE),
    .advance (w_xfer && !w_last),
    .carry   (w_carry),
    .term    (w_term)
  );

  // Flag is visible on the very beat that carries the first wrapped term.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ovf <= 1'b0;
    else      r_ovf <= r_ovf | (out_valid & w_carry);
  end

  assign ovf = r_ovf | (out_valid & w_carry);
`else
  fib_core #(.DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == IDLE),
    .advance (w_xfer && !w_last),
    .term    (w_term)
  );

  assign ovf = 1'b0;
`endif

  assign gnt0     = r_gnt & ~r_id;
  assign gnt1     = r_gnt &  r_id;
  assign out_id   = r_id;
  assign out_last = out_valid && w_last;
  assign out_data = out_valid ? w_term : '0;
  assign busy     = (r_state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_fib_sched.sv
// +----------------------------------------------------------------------+
// | tb_fib_sched                                                         |
// | Directed self-checking bench for fib_sched.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fib_sched;

`ifdef FIB_SCHED_OVF_EN
  localparam bit c_OVF_EN = 1'b1;
`else
  localparam bit c_OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [4:0]  len0, len1;
  logic        gnt0, gnt1;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_id, out_last, busy, ovf;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  fib_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .len0      (len0),
    .len1      (len1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .busy      (busy),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] fib(input int n);
    logic [15:0] a, b, t;
    a = 16'd0;
    b = 16'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic request(input int who, input logic [4:0] len);
    if (who == 0) begin req0 = 1'b1; len0 = len; end
    else          begin req1 = 1'b1; len1 = len; end
  endtask

  task automatic wait_gnt(input int who);
    logic g;
    g = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = (who == 0) ? gnt0 : gnt1;
      if (g) break;
    end
    check("gnt", {31'd0, g}, 32'd1);
    check("gnt_other", {31'd0, (who == 0) ? gnt1 : gnt0}, 32'd0);
    check("gnt_id", {31'd0, out_id}, who);
    check("gnt_busy", {31'd0, busy}, 32'd1);
    if (who == 0) req0 = 1'b0;
    else          req1 = 1'b0;
  endtask

  // Walks a burst from its first RUN cycle; mode 1 drives ready as 1,0,0 repeating.
  task automatic beats(input int who, input int len, input int mode, input int abort_at);
    int idx, cyc;
    bit done;
    idx  = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (abort_at >= 0 && out_valid && idx == abort_at) begin
        rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  {16'd0, out_data},  32'd0);
        check("rst_last",  {31'd0, out_last},  32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_id",    {31'd0, out_id},    32'd0);
        check("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_ovf",   {31'd0, ovf},       32'd0);
        exp_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (c_OVF_EN && out_valid && idx >= 25) exp_ovf = 1'b1;
      check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
      if (len == 0) begin
        check("zl_valid", {31'd0, out_valid}, 32'd0);
        check("zl_data",  {16'd0, out_data},  32'd0);
        done = 1'b1;
      end else begin
        check("valid", {31'd0, out_valid}, 32'd1);
        check("data",  {16'd0, out_data},  {16'd0, fib(idx)});
        check("last",  {31'd0, out_last},  (idx == len - 1) ? 32'd1 : 32'd0);
        check("id",    {31'd0, out_id},    who);
        if (idx == 25) check("f25", {16'd0, out_data}, 32'd9489);
        if (out_ready) begin
          if (idx == len - 1) done = 1'b1;
          idx++;
        end
      end
      cyc++;
    end
    if (!done) check("burst_timeout", 32'd0, 32'd1);
    check("beat_count", idx, len);
    @(negedge clk);
    out_ready = 1'b1;
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_busy",  {31'd0, busy},      32'd0);
    check("idle_data",  {16'd0, out_data},  32'd0);
    check("idle_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
    check("idle_last",  {31'd0, out_last},  32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    len0 = 5'd0; len1 = 5'd0;
    out_ready = 1'b1;
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy",  {31'd0, busy},      32'd0);
    check("reset_data",  {16'd0, out_data},  32'd0);
    check("reset_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
    check("reset_ovf",   {31'd0, ovf},       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous requests: 0, then 1, then 0 again.
    request(0, 5'd2);
    request(1, 5'd2);
    wait_gnt(0);
    beats(0, 2, 0, -1);
    wait_gnt(1);
    beats(1, 2, 0, -1);
    request(0, 5'd2);
    request(1, 5'd2);
    wait_gnt(0);
    beats(0, 2, 0, -1);
    wait_gnt(1);
    beats(1, 2, 0, -1);

    // Six-term burst at full rate.
    request(0, 5'd6);
    wait_gnt(0);
    beats(0, 6, 0, -1);

    // Backpressure on requester 1.
    request(1, 5'd4);
    wait_gnt(1);
    beats(1, 4, 1, -1);

    // Zero-length burst.
    request(0, 5'd0);
    wait_gnt(0);
    beats(0, 0, 0, -1);

    // Long burst past the 16-bit wrap.
    request(0, 5'd27);
    wait_gnt(0);
    beats(0, 27, 0, -1);
    check("ovf_sticky", {31'd0, ovf}, {31'd0, c_OVF_EN});

    // Reset in the middle of a burst, then a fresh burst.
    request(0, 5'd10);
    wait_gnt(0);
    beats(0, 10, 0, 3);
    request(0, 5'd3);
    wait_gnt(0);
    beats(0, 3, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
